// File: rtl/ccd_box_downsampler.sv
// Crops a square window out of a raw sensor stream and box-averages SCALE x SCALE tiles
// into an OUT_N x OUT_N frame, emitted as an FVAL/DVAL/DATA stream with one clock latency.
module ccd_box_downsampler #(
  parameter int unsigned IN_W  = 640,
  parameter int unsigned IN_H  = 480,
  parameter int unsigned X0    = 96,
  parameter int unsigned Y0    = 16,
  parameter int unsigned SCALE = 16,
  parameter int unsigned OUT_N = 28,
  parameter int unsigned IN_DW = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             fval_i,
  input  logic             dval_i,
  input  logic [IN_DW-1:0] data_i,
  output logic             fval_o,
  output logic             dval_o,
  output logic [15:0]      data_o,
  output logic [9:0]       pix_cnt_o,
  output logic             frame_done_o,
  output logic             frame_err_o
);

  localparam int unsigned CW    = $clog2(IN_W + 1);
  localparam int unsigned RW    = $clog2(IN_H + 1);
  localparam int unsigned LOG2S = $clog2(SCALE);
  localparam int unsigned SHIFT = 2 * LOG2S;
  localparam int unsigned AW    = IN_DW + SHIFT;
  localparam int unsigned TW    = (OUT_N > 1) ? $clog2(OUT_N) : 1;

  localparam logic [CW-1:0] XLo     = CW'(X0);
  localparam logic [CW-1:0] XHi     = CW'(X0 + OUT_N * SCALE);
  localparam logic [CW-1:0] LastCol = CW'(IN_W - 1);
  localparam logic [RW-1:0] YLo     = RW'(Y0);
  localparam logic [RW-1:0] YHi     = RW'(Y0 + OUT_N * SCALE);
  localparam logic [RW-1:0] RowEnd  = RW'(IN_H);
  localparam logic [9:0]    PixLast = 10'(OUT_N * OUT_N - 1);

  typedef enum logic [1:0] {StIdle, StSkip, StActive, StDone} state_e;

  state_e            state_q;
  logic              fval_prev_q;
  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  logic [AW-1:0]     acc_q [OUT_N];
  logic              fval_q, dval_q, done_q, err_q;
  logic [15:0]       data_q;
  logic [9:0]        pix_cnt_q;

  logic              fval_rise, beat, in_win, tile_first, tile_last;
  logic [CW-1:0]     cx;
  logic [TW-1:0]     tx;
  logic [LOG2S-1:0]  tile_col, ry;
  logic [AW-1:0]     sum;

  always_comb begin
    fval_rise  = fval_i & ~fval_prev_q;
    beat       = fval_i & dval_i & (row_q < RowEnd);
    in_win     = (col_q >= XLo) && (col_q < XHi) && (row_q >= YLo) && (row_q < YHi);
    cx         = col_q - XLo;
    tx         = TW'(cx >> LOG2S);
    tile_col   = LOG2S'(cx);
    ry         = LOG2S'(row_q - YLo);
    tile_first = (ry == '0) && (tile_col == '0);
    tile_last  = (ry == '1) && (tile_col == '1);
    sum        = acc_q[tx] + AW'(data_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      // Treat a frame already in progress at reset release as not-a-rising-edge.
      fval_prev_q <= 1'b1;
      col_q       <= '0;
      row_q       <= '0;
      for (int unsigned i = 0; i < OUT_N; i++) acc_q[i] <= '0;
      fval_q      <= 1'b0;
      dval_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      data_q      <= '0;
      pix_cnt_q   <= '0;
    end else begin
      fval_prev_q <= fval_i;
      dval_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          fval_q <= 1'b0;
          if (fval_rise) begin
            if (enable_i) begin
              state_q   <= StActive;
              fval_q    <= 1'b1;
              col_q     <= '0;
              row_q     <= '0;
              pix_cnt_q <= '0;
            end else begin
              state_q <= StSkip;
            end
          end
        end
        StSkip: begin
          if (!fval_i) state_q <= StIdle;
        end
        StActive: begin
          if (!fval_i) begin
            err_q   <= 1'b1;
            fval_q  <= 1'b0;
            state_q <= StIdle;
          end else if (beat) begin
            if (col_q == LastCol) begin
              col_q <= '0;
              row_q <= row_q + RW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
            if (in_win) begin
              acc_q[tx] <= tile_first ? AW'(data_i) : sum;
              if (tile_last) begin
                data_q    <= 16'(sum >> SHIFT);
                dval_q    <= 1'b1;
                pix_cnt_q <= pix_cnt_q + 10'd1;
                if (pix_cnt_q == PixLast) begin
                  done_q  <= 1'b1;
                  state_q <= StDone;
                end
              end
            end
          end
        end
        StDone: begin
          fval_q <= 1'b0;
          if (!fval_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign fval_o       = fval_q;
  assign dval_o       = dval_q;
  assign data_o       = data_q;
  assign pix_cnt_o    = pix_cnt_q;
  assign frame_done_o = done_q;
  assign frame_err_o  = err_q;

endmodule

// File: tb/tb_ccd_box_downsampler.sv
// Scoreboard bench for ccd_box_downsampler on a reduced sensor geometry so every
// scenario fits a short run; expected tile averages come from direct tile sums.
module tb_ccd_box_downsampler;

  localparam int IW = 40;
  localparam int IH = 40;
  localparam int BX = 5;
  localparam int BY = 3;
  localparam int S  = 4;
  localparam int N  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, fval, dval;
  logic [11:0] data;
  logic        fval_o, dval_o, frame_done_o, frame_err_o;
  logic [15:0] data_o;
  logic [9:0]  pix_cnt_o;

  ccd_box_downsampler #(
    .IN_W(IW), .IN_H(IH), .X0(BX), .Y0(BY), .SCALE(S), .OUT_N(N), .IN_DW(12)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable),
    .fval_i       (fval),
    .dval_i       (dval),
    .data_i       (data),
    .fval_o       (fval_o),
    .dval_o       (dval_o),
    .data_o       (data_o),
    .pix_cnt_o    (pix_cnt_o),
    .frame_done_o (frame_done_o),
    .frame_err_o  (frame_err_o)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_bad = 0;
  int          n_dval, n_done, n_err;
  bit          pending_emit = 1'b0;
  bit          exp_dv;
  bit          fval_chk = 1'b0;
  logic [15:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [11:0] pix(input int p, input int c, input int r);
    case (p)
      0:       return 12'h800;
      1:       return 12'(c);
      default: return 12'((c * 37 + r * 101 + (c ^ r) * 13) & 'hfff);
    endcase
  endfunction

  function automatic logic [15:0] tile_avg(input int p, input int cl, input int rl);
    int s = 0;
    for (int r = rl - S + 1; r <= rl; r++)
      for (int c = cl - S + 1; c <= cl; c++) s += int'(pix(p, c, r));
    return 16'(s / (S * S));
  endfunction

  function automatic bit is_last(input int c, input int r);
    return c >= BX && c < BX + N * S && (c - BX) % S == S - 1 &&
           r >= BY && r < BY + N * S && (r - BY) % S == S - 1;
  endfunction

  // Output-side monitor: latency, scoreboard data, pulse bookkeeping.
  always @(posedge clk) begin
    exp_dv = pending_emit;
    #1;
    if (fval_chk) chk("fval_low_after_end", fval_o, 0);
    fval_chk = 1'b0;
    if (dval_o || exp_dv) chk("dval_latency", dval_o, exp_dv);
    if (dval_o) begin
      n_dval++;
      chk("sb_avail", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("data", data_o, exp_q.pop_front());
    end
    if (frame_done_o) begin
      n_done++;
      chk("done_with_dval", dval_o, 1);
      chk("done_pix", pix_cnt_o, N * N);
      fval_chk = 1'b1;
    end
    if (frame_err_o) begin
      n_err++;
      fval_chk = 1'b1;
    end
  end

  task automatic drive_frame(input int pat, input bit en, input int nlines, input int gap,
                             input int rst_row, input bit en_mid);
    bit cap;
    int exp_pix, exp_cnt;
    n_dval = 0; n_done = 0; n_err = 0;
    cap = en; exp_pix = 0; exp_cnt = 0;
    fval = 1'b1; enable = en; dval = 1'b0; pending_emit = 1'b0;
    repeat (2) @(negedge clk);
    enable = en_mid;
    for (int r = 0; r < nlines; r++) begin
      for (int c = 0; c < IW; c++) begin
        if (c == 0 && r == rst_row) begin
          rst_n = 1'b0;
          cap = 1'b0;
          exp_pix = 0;
          #1;
          chk("arst_fval", fval_o, 0);
          chk("arst_dval", dval_o, 0);
          chk("arst_data", data_o, 0);
          chk("arst_pix", pix_cnt_o, 0);
          chk("arst_sb_empty", exp_q.size(), 0);
          @(negedge clk);
          rst_n = 1'b1;
        end
        if (c == 0 && r == BY) chk("fval_mid", fval_o, cap);
        dval = 1'b1;
        data = pix(pat, c, r);
        pending_emit = cap && is_last(c, r);
        if (pending_emit) begin
          exp_q.push_back(tile_avg(pat, c, r));
          exp_pix++;
          exp_cnt++;
        end
        @(negedge clk);
        dval = 1'b0;
        pending_emit = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
      repeat (2) @(negedge clk);
    end
    fval = 1'b0;
    repeat (4) @(negedge clk);
    chk("n_dval", n_dval, exp_cnt);
    chk("n_done", n_done, (cap && exp_pix == N * N) ? 1 : 0);
    chk("n_err", n_err, (cap && exp_pix != N * N) ? 1 : 0);
    chk("fval_idle", fval_o, 0);
    chk("sb_drained", exp_q.size(), 0);
    if (en) chk("pix_cnt", pix_cnt_o, exp_pix);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; fval = 1'b0; dval = 1'b0; data = '0;
    repeat (3) @(negedge clk);
    chk("rst_fval", fval_o, 0);
    chk("rst_dval", dval_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_pix", pix_cnt_o, 0);
    chk("rst_done", frame_done_o, 0);
    chk("rst_err", frame_err_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    drive_frame(0, 1'b1, IH, 1, -1, 1'b1);          // constant frame
    drive_frame(1, 1'b1, IH, 1, -1, 1'b1);          // column ramp
    drive_frame(0, 1'b0, IH, 1, -1, 1'b1);          // disarmed at rise, armed mid-frame
    drive_frame(2, 1'b1, IH, 1, -1, 1'b1);          // next armed frame captures
    drive_frame(1, 1'b1, BY + 4 * S + 2, 1, -1, 1'b1); // early frame end
    drive_frame(0, 1'b1, IH, 3, -1, 1'b1);          // gapped strobes
    drive_frame(2, 1'b1, IH, 1, 20, 1'b1);          // async reset mid-frame
    drive_frame(2, 1'b1, IH, 1, -1, 1'b1);          // clean recovery frame

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
